// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - calculator op-code constants and ALU state encoding
package calc_pkg;

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_MUL = 3'b010;
    localparam logic [2:0] CMD_DIV = 3'b011;
    localparam logic [2:0] CMD_MOD = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic logic is_div_cmd(input logic [2:0] op);
        return (op == CMD_DIV) || (op == CMD_MOD);
    endfunction

endpackage

// File: rtl/calc_seq_div.sv
// rtl/calc_seq_div.sv - restoring divider, one quotient bit per clock, WIDTH steps
module calc_seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH-1:0] next_rem, next_quo;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [CW-1:0]    cnt;
    logic             active;

    // The first step runs on the start edge itself, so the final bit lands WIDTH-1 edges later.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvs  = start ? divisor : dvs_q;
        shifted  = {src_rem, src_quo[WIDTH-1]};
        ge       = shifted >= {1'b0, src_dvs};
        next_rem = ge ? WIDTH'(shifted - {1'b0, src_dvs}) : shifted[WIDTH-1:0];
        next_quo = {src_quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= next_rem;
                quo_q  <= next_quo;
                dvs_q  <= divisor;
                cnt    <= CW'(1);
                active <= (WIDTH > 1);
                done   <= (WIDTH == 1);
            end else if (active) begin
                rem_q <= next_rem;
                quo_q <= next_quo;
                cnt   <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - multi-cycle unsigned ALU; define CALC_ALU_OVF_EN to flag overflow on err
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef CALC_ALU_OVF_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [PW-1:0]    mcand, prod, prod_next;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] fast_res, quo, rem;
    logic             fast_err, slow, div_start, div_done;

    // Single-cycle results; anything not ADD/SUB that reaches here is illegal or divide-by-zero.
    always_comb begin
        slow     = (op == CMD_MUL) || (is_div_cmd(op) && (b != '0));
        fast_res = '0;
        fast_err = 1'b1;
        case (op)
            CMD_ADD: begin
`ifdef CALC_ALU_OVF_EN
                {fast_err, fast_res} = {1'b0, a} + {1'b0, b};
`else
                fast_res = a + b;
                fast_err = 1'b0;
`endif
            end
            CMD_SUB: begin
                fast_res = a - b;
`ifdef CALC_ALU_OVF_EN
                fast_err = a < b;
`else
                fast_err = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign div_start = (state == ST_IDLE) && start && is_div_cmd(op) && (b != '0);
    assign prod_next = prod + (mplier[0] ? mcand : '0);

    calc_seq_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= CMD_ADD;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        cnt    <= '0;
                        mcand  <= PW'(a);
                        mplier <= b;
                        prod   <= '0;
                        if (slow) begin
                            state <= ST_RUN;
                        end else begin
                            state  <= ST_FIN;
                            result <= fast_res;
                            err    <= fast_err;
                        end
                    end
                end
                ST_RUN: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    prod   <= prod_next;
                    if (cnt == LAST) begin
                        state <= ST_FIN;
                        if (op_q == CMD_MUL) begin
                            result <= prod_next[WIDTH-1:0];
`ifdef CALC_ALU_OVF_EN
                            err <= |prod_next[PW-1:WIDTH];
`else
                            err <= 1'b0;
`endif
                        end else begin
                            result <= div_done ? ((op_q == CMD_MOD) ? rem : quo) : '0;
                            err    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_FIN);

endmodule

// File: doc/calc_alu.md
CALC_ALU -- requirements
Module: calc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; iteration count of multi-cycle ops equals WIDTH.
REQ-002 SHALL have port clk  input  1  rising-edge clock (mclk domain).
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  command: ADD=000, SUB=001, MUL=010, DIV=011, MOD=100; 101..111 illegal for this block.
REQ-006 SHALL have port a  input  WIDTH  left operand (second stack element, top1).
REQ-007 SHALL have port b  input  WIDTH  right operand (stack top, top0).
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port result  output  WIDTH  a op b; valid while done=1, held until next acceptance.
REQ-011 SHALL have port err  output  1  error qualifier, valid while done=1.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE; FIN lasts exactly one cycle with done=1, busy=0.
REQ-013 SHALL accept start only when state=IDLE, capturing a, b and op into internal registers; start in RUN/FIN is ignored and not queued.
REQ-014 SHALL treat operands as unsigned; ADD/SUB/MUL results wrap modulo 2^WIDTH.
REQ-015 ADD, SUB, illegal op, DIV/MOD with b=0: SHALL skip RUN; done rises in the cycle after acceptance (latency 1).
REQ-016 MUL: SHALL use a shift-add over WIDTH RUN cycles; done rises WIDTH+1 cycles after acceptance (33 at default).
REQ-017 DIV/MOD: SHALL use restoring division over WIDTH RUN cycles; DIV returns quotient, MOD remainder; latency WIDTH+1.
REQ-018 SHALL hold an iteration counter, 0..WIDTH-1, cleared on acceptance; RUN exits when counter reaches WIDTH-1.
REQ-019 Division by zero SHALL give result=0, err=1.
REQ-020 Illegal op SHALL give result=0, err=1.
REQ-021 SHALL keep inputs a, b, op free to change after acceptance without affecting the result.
REQ-022 start asserted in the FIN cycle SHALL be ignored; a new start is accepted earliest in the following IDLE cycle.
REQ-023 err SHALL be 0 for every legal, non-faulting op when CALC_ALU_OVF_EN is undefined.

Reset
REQ-024 rst_n low SHALL force asynchronously: state=IDLE, busy=0, done=0, err=0, result=0, counter=0.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; first accepted start after release behaves normally.

Configuration
REQ-026 Macro CALC_ALU_OVF_EN defined: err=1 additionally on ADD carry-out, SUB borrow (a<b), MUL product exceeding WIDTH bits; result remains the wrapped value.
REQ-027 Macro CALC_ALU_OVF_EN undefined: no overflow logic synthesised; overflow wraps silently with err=0.

Structure
REQ-028 Package calc_pkg SHALL hold the CMD_* op-code constants (shared with the calculator controller) and the ALU state enumeration.
REQ-029 Restoring divider SHALL be a sub-module calc_seq_div (start, dividend, divisor, quotient, remainder, done); multiplier stays inline.

Verification
REQ-030 ADD: a=0x0000_00FF, b=0x0000_0001, start -> next cycle done=1, result=0x0000_0100, err=0.
REQ-031 MUL: a=0x0001_0000, b=0x0001_0000 -> done exactly 33 cycles after start, result=0; err=1 only with CALC_ALU_OVF_EN.
REQ-032 DIV/MOD: a=100, b=7 -> DIV result=14, MOD result=2, each done at latency 33, err=0.
REQ-033 DIV a=5, b=0 -> done at latency 1, result=0, err=1; op=101 -> same response.
REQ-034 Start MUL, pulse start with op=ADD at cycle 10, deassert rst_n at cycle 20 -> ADD ignored, no done, all outputs 0; fresh SUB a=3, b=5 after release -> result=0xFFFF_FFFE, err per REQ-026/027.
